// File: rtl/apb_slot_controller.sv
// -----------------------------------------------------------------------------
// apb_slot_controller
//
// Purpose:
//   Bridges the MSS fabric APB master port to up to NSLOTS fabric APB
//   peripherals. Each master transfer is decoded to one slot using a 4-bit
//   field of MSSPADDR. The transfer is then replayed as a clean APB3
//   SETUP/ACCESS sequence on the slave side. The slave response is returned
//   to the master.
//   Unmapped slots and slaves that hold PREADY low for TIMEOUT access cycles
//   are answered with PSLVERR. Error statistics are kept in ERR_COUNT and
//   LAST_ERR_ADDR.
//
// Ports:
//   SYSCLK, SYSRESET       clock (rising edge) and synchronous active-high reset
//   MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA   master request
//   MSSPRDATA/MSSPREADY/MSSPSLVERR                    master response
//   S_PSEL[NSLOTS]         one-hot slave select
//   S_PENABLE, S_PWRITE    shared slave enable / write
//   S_PADDR[8], S_PWDATA   shared slave address (MSSPADDR[7:0]) and write data
//   S_PRDATA[32*NSLOTS]    per-slot read data, slot i at [32i+31:32i]
//   S_PREADY, S_PSLVERR    per-slot ready / error
//   ERR_COUNT[8]           saturating count of error responses
//   LAST_ERR_ADDR[32]      master address of the most recent errored transfer
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module apb_slot_controller #(
    parameter int NSLOTS   = 4,
    parameter int SLOT_LSB = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic                   SYSCLK,
    input  logic                   SYSRESET,
    input  logic                   MSSPSEL,
    input  logic                   MSSPENABLE,
    input  logic                   MSSPWRITE,
    input  logic [31:0]            MSSPADDR,
    input  logic [31:0]            MSSPWDATA,
    output logic [31:0]            MSSPRDATA,
    output logic                   MSSPREADY,
    output logic                   MSSPSLVERR,
    output logic [NSLOTS-1:0]      S_PSEL,
    output logic                   S_PENABLE,
    output logic                   S_PWRITE,
    output logic [7:0]             S_PADDR,
    output logic [31:0]            S_PWDATA,
    input  logic [32*NSLOTS-1:0]   S_PRDATA,
    input  logic [NSLOTS-1:0]      S_PREADY,
    input  logic [NSLOTS-1:0]      S_PSLVERR,
    output logic [7:0]             ERR_COUNT,
    output logic [31:0]            LAST_ERR_ADDR
);

    // Abort happens on the TIMEOUT-th consecutive not-ready access cycle.
    // The counter holds (cycles waited so far - 1) when compared.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FWD_SETUP  = 2'd1,
        FWD_ACCESS = 2'd2,
        RESP       = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [NSLOTS-1:0]   psel_q,     psel_d;
    logic                penable_q,  penable_d;
    logic                pwrite_q,   pwrite_d;
    logic [7:0]          paddr_q,    paddr_d;
    logic [31:0]         pwdata_q,   pwdata_d;
    logic [31:0]         addr_q,     addr_d;
    logic [31:0]         rdata_q,    rdata_d;
    logic                ready_q,    ready_d;
    logic                slverr_q,   slverr_d;
    logic [7:0]          err_cnt_q,  err_cnt_d;
    logic [31:0]         last_err_q, last_err_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;

    // ---------------------------------------------------------------------
    // Slot decode. An all-zero decode means the slot field points past the
    // last implemented slot, i.e. the access is unmapped.
    // ---------------------------------------------------------------------
    logic [3:0]        slot;
    logic [NSLOTS-1:0] slot_dec;
    logic              slot_mapped;
    logic              start;

    assign slot        = MSSPADDR[SLOT_LSB+3:SLOT_LSB];
    assign slot_mapped = |slot_dec;
    // Only the master SETUP phase starts a transfer; an ACCESS-phase
    // PENABLE=1 is never mistaken for a new request.
    assign start       = MSSPSEL & ~MSSPENABLE;

    generate
        for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_dec
            assign slot_dec[gi] = (slot == 4'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Response mux. The registered one-hot select doubles as the mux
    // control. Unselected slots therefore cannot leak ready, error or data.
    // ---------------------------------------------------------------------
    logic [31:0] rd_masked [NSLOTS];
    logic [31:0] sel_rdata;
    logic        sel_ready;
    logic        sel_err;

    generate
        for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_rmux
            assign rd_masked[gi] = S_PRDATA[32*gi +: 32] & {32{psel_q[gi]}};
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            sel_rdata = sel_rdata | rd_masked[i];
        end
    end

    assign sel_ready = |(S_PREADY  & psel_q);
    assign sel_err   = |(S_PSLVERR & psel_q);

    // ---------------------------------------------------------------------
    // Next-state and next-output logic
    // ---------------------------------------------------------------------
    logic        err_event;
    logic [31:0] err_addr;

    always_comb begin
        state_d    = state_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;
        slverr_d   = slverr_q;
        wait_cnt_d = wait_cnt_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        err_event  = 1'b0;
        err_addr   = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = MSSPADDR;
                    if (slot_mapped) begin
                        psel_d    = slot_dec;
                        penable_d = 1'b0;
                        pwrite_d  = MSSPWRITE;
                        paddr_d   = MSSPADDR[7:0];
                        pwdata_d  = MSSPWDATA;
                        state_d   = FWD_SETUP;
                    end else begin
                        // Answer without touching the slave bus. The address
                        // is latched in this same edge, so the error record
                        // takes it directly from the master bus.
                        ready_d   = 1'b1;
                        slverr_d  = 1'b1;
                        rdata_d   = '0;
                        state_d   = RESP;
                        err_event = 1'b1;
                        err_addr  = MSSPADDR;
                    end
                end
            end

            FWD_SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = FWD_ACCESS;
            end

            FWD_ACCESS: begin
                if (sel_ready) begin
                    rdata_d   = pwrite_q ? 32'd0 : sel_rdata;
                    slverr_d  = sel_err;
                    ready_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                    err_event = sel_err;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    // The slave is hung. Abandon the transfer on the slave side
                    // and report an error to the master.
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    ready_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = RESP;
                    err_event = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            RESP: begin
                // MSSPREADY is a single-cycle pulse. All master outputs
                // return to zero afterwards.
                ready_d  = 1'b0;
                slverr_d = 1'b0;
                rdata_d  = '0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Statistics are updated in the edge that enters RESP. They are
        // therefore already visible while MSSPREADY is high.
        if (err_event) begin
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            last_err_d = err_addr;
        end
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state_q    <= IDLE;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            slverr_q   <= 1'b0;
            wait_cnt_q <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            slverr_q   <= slverr_d;
            wait_cnt_q <= wait_cnt_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    assign MSSPRDATA     = rdata_q;
    assign MSSPREADY     = ready_q;
    assign MSSPSLVERR    = slverr_q;
    assign S_PSEL        = psel_q;
    assign S_PENABLE     = penable_q;
    assign S_PWRITE      = pwrite_q;
    assign S_PADDR       = paddr_q;
    assign S_PWDATA      = pwdata_q;
    assign ERR_COUNT     = err_cnt_q;
    assign LAST_ERR_ADDR = last_err_q;

endmodule

// File: tb/tb_apb_slot_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_slot_controller
//
// Drives master transfers and plays every slave from a single task.
// Each transfer is scored against a reference model of the controller.
// The model works from the protocol rules: the latency per outcome, the
// expected response and the error statistics.
// -----------------------------------------------------------------------------
module tb_apb_slot_controller;

    localparam int NSLOTS   = 4;
    localparam int SLOT_LSB = 8;
    localparam int TIMEOUT  = 8;

    logic                  SYSCLK = 1'b0;
    logic                  SYSRESET;
    logic                  MSSPSEL;
    logic                  MSSPENABLE;
    logic                  MSSPWRITE;
    logic [31:0]           MSSPADDR;
    logic [31:0]           MSSPWDATA;
    logic [31:0]           MSSPRDATA;
    logic                  MSSPREADY;
    logic                  MSSPSLVERR;
    logic [NSLOTS-1:0]     S_PSEL;
    logic                  S_PENABLE;
    logic                  S_PWRITE;
    logic [7:0]            S_PADDR;
    logic [31:0]           S_PWDATA;
    logic [32*NSLOTS-1:0]  S_PRDATA;
    logic [NSLOTS-1:0]     S_PREADY;
    logic [NSLOTS-1:0]     S_PSLVERR;
    logic [7:0]            ERR_COUNT;
    logic [31:0]           LAST_ERR_ADDR;

    apb_slot_controller #(
        .NSLOTS   (NSLOTS),
        .SLOT_LSB (SLOT_LSB),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .SYSCLK        (SYSCLK),
        .SYSRESET      (SYSRESET),
        .MSSPSEL       (MSSPSEL),
        .MSSPENABLE    (MSSPENABLE),
        .MSSPWRITE     (MSSPWRITE),
        .MSSPADDR      (MSSPADDR),
        .MSSPWDATA     (MSSPWDATA),
        .MSSPRDATA     (MSSPRDATA),
        .MSSPREADY     (MSSPREADY),
        .MSSPSLVERR    (MSSPSLVERR),
        .S_PSEL        (S_PSEL),
        .S_PENABLE     (S_PENABLE),
        .S_PWRITE      (S_PWRITE),
        .S_PADDR       (S_PADDR),
        .S_PWDATA      (S_PWDATA),
        .S_PRDATA      (S_PRDATA),
        .S_PREADY      (S_PREADY),
        .S_PSLVERR     (S_PSLVERR),
        .ERR_COUNT     (ERR_COUNT),
        .LAST_ERR_ADDR (LAST_ERR_ADDR)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_no  = 0;

    // Reference model state
    int          m_err_cnt  = 0;
    logic [31:0] m_last_err = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Unselected slaves present random ready, error and data. The controller
    // must ignore all of it.
    task automatic slaves_random();
        for (int i = 0; i < NSLOTS; i++) begin
            S_PREADY[i]          = 1'($urandom_range(0, 1));
            S_PSLVERR[i]         = 1'($urandom_range(0, 1));
            S_PRDATA[32*i +: 32] = $urandom;
        end
    endtask

    // Runs one complete master transfer and checks it. The task must be
    // called at a negedge. It returns at the negedge of the cycle that follows
    // the response, with the master idle. Calling it again immediately gives a
    // back-to-back SETUP.
    //   waits : slave wait states; values >= TIMEOUT make the slave hang
    //   sdata : data returned by the slave on a read
    //   serr  : PSLVERR returned by the slave
    task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] sdata, input bit serr);
        int                slot;
        bit                unmapped;
        bit                tmo;
        bit                exp_err;
        bit                done;
        bit                side_ok;
        int                exp_lat;
        int                exp_psel_cycles;
        int                lat;
        int                slave_acc;
        int                psel_cycles;
        int                pen_cycles;
        logic [31:0]       exp_rdata;
        logic [31:0]       got_rdata;
        logic              got_err;
        logic [7:0]        got_cnt;
        logic [31:0]       got_last;
        logic [NSLOTS-1:0] one_v;
        logic [NSLOTS-1:0] exp_psel;
        logic [NSLOTS-1:0] psel_seen;

        slot     = int'(addr[SLOT_LSB +: 4]);
        unmapped = (slot >= NSLOTS);
        tmo      = !unmapped && (waits >= TIMEOUT);
        exp_err  = unmapped || tmo || serr;
        exp_lat  = unmapped ? 1 : (tmo ? 2 + TIMEOUT : 3 + waits);
        exp_psel_cycles = unmapped ? 0 : (tmo ? 1 + TIMEOUT : 2 + waits);
        exp_rdata = (unmapped || tmo || wr) ? 32'd0 : sdata;
        one_v    = 1;
        exp_psel = unmapped ? '0 : (one_v << slot);

        // Master SETUP cycle
        MSSPSEL    = 1'b1;
        MSSPENABLE = 1'b0;
        MSSPWRITE  = wr;
        MSSPADDR   = addr;
        MSSPWDATA  = wdata;
        slaves_random();
        @(negedge SYSCLK);
        MSSPENABLE = 1'b1;

        lat = 0; slave_acc = 0; psel_cycles = 0; pen_cycles = 0;
        psel_seen = '0; side_ok = 1'b1; done = 1'b0;
        got_rdata = '0; got_err = 1'b0; got_cnt = '0; got_last = '0;

        while (!done && lat < exp_lat + 8) begin
            lat++;
            // Watch the slave bus during this access cycle
            if (S_PSEL != '0) begin
                psel_cycles++;
                psel_seen = psel_seen | S_PSEL;
                if (S_PENABLE) pen_cycles++;
                if (S_PADDR !== addr[7:0] || S_PWDATA !== wdata || S_PWRITE !== wr)
                    side_ok = 1'b0;
            end
            // Play the slaves for this cycle
            slaves_random();
            for (int i = 0; i < NSLOTS; i++) begin
                if (S_PSEL[i] && S_PENABLE) begin
                    if (!tmo && slave_acc == waits) begin
                        S_PREADY[i]          = 1'b1;
                        S_PSLVERR[i]         = serr;
                        S_PRDATA[32*i +: 32] = sdata;
                    end else begin
                        S_PREADY[i] = 1'b0;
                    end
                end
            end
            if (S_PENABLE && S_PSEL != '0) slave_acc++;

            if (MSSPREADY) begin
                done      = 1'b1;
                got_rdata = MSSPRDATA;
                got_err   = MSSPSLVERR;
                got_cnt   = ERR_COUNT;
                got_last  = LAST_ERR_ADDR;
            end else begin
                @(negedge SYSCLK);
            end
        end

        // Reference model: error statistics
        if (exp_err) begin
            if (m_err_cnt < 255) m_err_cnt++;
            m_last_err = addr;
        end

        check_val("completed", 32'(done), 32'd1);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("rdata", got_rdata, exp_rdata);
        check_val("slverr", 32'(got_err), 32'(exp_err));
        check_val("psel_slot", 32'(psel_seen), 32'(exp_psel));
        check_val("psel_cycles", 32'(psel_cycles), 32'(exp_psel_cycles));
        check_val("penable_cycles", 32'(pen_cycles),
                  unmapped ? 32'd0 : 32'(exp_psel_cycles - 1));
        check_val("slave_side_stable", 32'(side_ok), 32'd1);
        check_val("err_count", 32'(got_cnt), 32'(m_err_cnt));
        check_val("last_err_addr", got_last, m_last_err);

        $display("xfer %0d: %s addr=%08h slot=%0d waits=%0d lat=%0d rdata=%08h err=%0b errcnt=%0d",
                 xfer_no, wr ? "WR" : "RD", addr, slot, waits, lat, got_rdata, got_err, got_cnt);
        xfer_no++;

        // The cycle after the response: the ready pulse is over and the
        // master outputs are back to zero.
        @(negedge SYSCLK);
        MSSPSEL    = 1'b0;
        MSSPENABLE = 1'b0;
        check_val("ready_pulse", 32'(MSSPREADY), 32'd0);
        check_val("slverr_clear", 32'(MSSPSLVERR), 32'd0);
        check_val("rdata_clear", MSSPRDATA, 32'd0);
    endtask

    function automatic logic [31:0] mk_addr(input int slot);
        logic [31:0] a;
        a = $urandom;
        a[SLOT_LSB +: 4] = 4'(slot);
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          slot;
        int          idles;

        SYSRESET = 1'b1;
        MSSPSEL = 1'b0; MSSPENABLE = 1'b0; MSSPWRITE = 1'b0;
        MSSPADDR = '0; MSSPWDATA = '0;
        S_PRDATA = '0; S_PREADY = '0; S_PSLVERR = '0;
        repeat (3) @(negedge SYSCLK);

        // Reset state
        check_val("rst_ready", 32'(MSSPREADY), 32'd0);
        check_val("rst_slverr", 32'(MSSPSLVERR), 32'd0);
        check_val("rst_rdata", MSSPRDATA, 32'd0);
        check_val("rst_psel", 32'(S_PSEL), 32'd0);
        check_val("rst_penable", 32'(S_PENABLE), 32'd0);
        check_val("rst_pwrite", 32'(S_PWRITE), 32'd0);
        check_val("rst_paddr", 32'(S_PADDR), 32'd0);
        check_val("rst_pwdata", S_PWDATA, 32'd0);
        check_val("rst_errcnt", 32'(ERR_COUNT), 32'd0);
        check_val("rst_lasterr", LAST_ERR_ADDR, 32'd0);
        SYSRESET = 1'b0;
        @(negedge SYSCLK);

        // Directed transfers
        do_xfer(32'h4005_0104, 1'b1, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0);
        do_xfer(32'h4005_0210, 1'b0, 32'h0BAD_F00D, 3, 32'h1234_5678, 1'b0);
        do_xfer(32'h4005_0500, 1'b0, 32'h0000_0000, 0, 32'h5555_5555, 1'b0);
        @(negedge SYSCLK);
        // Hung slot 0 followed back-to-back by a normal slot 3 access
        do_xfer(32'h4005_0000, 1'b0, 32'h1111_2222, 50, 32'h3333_4444, 1'b0);
        do_xfer(32'h4005_0308, 1'b0, 32'h0, 1, 32'hCAFE_0003, 1'b0);
        // Slot 3 reports a slave error
        do_xfer(32'h4005_031C, 1'b1, 32'h7777_8888, 2, 32'h0, 1'b1);
        // Boundary wait counts around the timeout
        do_xfer(32'h4005_0144, 1'b0, 32'h0, TIMEOUT - 1, 32'h0F0F_0F0F, 1'b0);
        do_xfer(32'h4005_0244, 1'b0, 32'h0, TIMEOUT, 32'hF0F0_F0F0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            slot = ($urandom_range(0, 3) == 0) ? $urandom_range(NSLOTS, 15)
                                              : $urandom_range(0, NSLOTS - 1);
            a = mk_addr(slot);
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TIMEOUT + 2),
                    $urandom, ($urandom_range(0, 3) == 0));
            idles = $urandom_range(0, 2);
            repeat (idles) @(negedge SYSCLK);
        end

        // Saturate the error counter
        for (int n = 0; n < 300; n++) begin
            do_xfer(mk_addr(3), 1'($urandom_range(0, 1)), $urandom, 0, $urandom, 1'b1);
        end
        check_val("err_saturated", 32'(ERR_COUNT), 32'd255);

        // Reset while the slave side is in its ACCESS phase
        S_PREADY = '0;
        MSSPSEL = 1'b1; MSSPENABLE = 1'b0; MSSPWRITE = 1'b0; MSSPADDR = 32'h4005_0000;
        @(negedge SYSCLK);
        MSSPENABLE = 1'b1;
        @(negedge SYSCLK);
        check_val("pre_rst_penable", 32'(S_PENABLE), 32'd1);
        SYSRESET = 1'b1;
        @(negedge SYSCLK);
        check_val("midrst_psel", 32'(S_PSEL), 32'd0);
        check_val("midrst_penable", 32'(S_PENABLE), 32'd0);
        check_val("midrst_ready", 32'(MSSPREADY), 32'd0);
        check_val("midrst_errcnt", 32'(ERR_COUNT), 32'd0);
        SYSRESET = 1'b0;
        MSSPSEL = 1'b0; MSSPENABLE = 1'b0;
        m_err_cnt  = 0;
        m_last_err = 32'd0;
        @(negedge SYSCLK);
        do_xfer(32'h4005_0220, 1'b0, 32'h0, 2, 32'h600D_DA7A, 1'b0);
        do_xfer(32'h4005_0F00, 1'b1, 32'h1, 0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slot_controller.md
Name: apb_slot_controller

Overview:
- Sits between the MSS fabric APB master port (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA in; MSSPRDATA/MSSPREADY/MSSPSLVERR out) and up to NSLOTS fabric APB peripherals, such as the CC3000 IRQ/enable block and the GPIO shadow registers.
- Decodes each master transfer to one slot and re-sequences it as a clean APB3 transfer on the slave side.
- Returns the slave's response to the master.
- Converts unmapped accesses and hung slaves (timeout) into PSLVERR responses, and keeps error statistics.

Parameters:
- NSLOTS, 4, number of slave slots (1..16).
- SLOT_LSB, 8, LSB of the 4-bit slot field in MSSPADDR; slot = MSSPADDR[SLOT_LSB+3:SLOT_LSB].
- TIMEOUT, 1023, maximum slave ACCESS cycles with S_PREADY low before abort (1..65535).

Ports:
- SYSCLK  in  1  fabric clock; all logic on rising edge.
- SYSRESET  in  1  synchronous, active-high reset.
- MSSPSEL  in  1  master select.
- MSSPENABLE  in  1  master enable.
- MSSPWRITE  in  1  master write strobe.
- MSSPADDR  in  32  master address.
- MSSPWDATA  in  32  master write data.
- MSSPRDATA  out  32  read data to master.
- MSSPREADY  out  1  ready to master.
- MSSPSLVERR  out  1  error to master.
- S_PSEL  out  NSLOTS  one-hot slave select.
- S_PENABLE  out  1  slave enable, shared by all slots.
- S_PWRITE  out  1  slave write, shared.
- S_PADDR  out  8  slave address = latched MSSPADDR[7:0].
- S_PWDATA  out  32  latched write data.
- S_PRDATA  in  32*NSLOTS  slot i read data at bits [32i+31:32i].
- S_PREADY  in  NSLOTS  per-slot ready.
- S_PSLVERR  in  NSLOTS  per-slot error.
- ERR_COUNT  out  8  saturating count of error responses.
- LAST_ERR_ADDR  out  32  MSSPADDR of the most recent errored transfer.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE. Reset mid-transfer abandons the transfer on both sides, with no response to the master.
- States: IDLE, FWD_SETUP, FWD_ACCESS, RESP.
- IDLE:
  - Start condition is MSSPSEL=1 and MSSPENABLE=0, i.e. the master SETUP cycle.
  - On start, latch MSSPADDR, MSSPWRITE and MSSPWDATA.
  - If slot < NSLOTS: go to FWD_SETUP and assert S_PSEL[slot], with S_PENABLE=0.
  - If slot >= NSLOTS (unmapped): go to RESP with MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0. The slave side is untouched.
- FWD_SETUP: lasts one cycle, then S_PENABLE=1 and go to FWD_ACCESS. Clear the timeout counter.
- FWD_ACCESS, when S_PREADY[slot]=1:
  - Capture S_PRDATA for the slot (reads; writes return 0) and S_PSLVERR[slot].
  - Drop S_PSEL and S_PENABLE.
  - Go to RESP with MSSPREADY=1 and MSSPSLVERR = the captured error.
- FWD_ACCESS, when S_PREADY[slot]=0: increment the counter. When the counter reaches TIMEOUT, abort:
  - Drop S_PSEL and S_PENABLE.
  - Go to RESP with MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0.
- RESP: MSSPREADY is high for exactly one cycle, then deassert all master outputs and go to IDLE.
- Back-to-back transfers: a new SETUP seen in the cycle after RESP is accepted normally. MSSPSEL/MSSPENABLE seen while not in IDLE are never treated as a new start.
- Latency, counted in master ACCESS cycles up to and including the MSSPREADY=1 cycle:
  - Unmapped: 1 (no wait state).
  - Mapped: 3 + N, where N is the number of slave wait states.
  - Timeout: 2 + TIMEOUT.
- Error accounting: any response with MSSPSLVERR=1 updates both status outputs in the RESP-entry cycle.
  - ERR_COUNT increments, saturating at 255 (no wrap).
  - LAST_ERR_ADDR loads the latched address.
- Master protocol violation (MSSPSEL dropped mid-transfer): the slave transfer still completes and RESP still pulses. No other recovery is performed.
- S_PADDR, S_PWRITE and S_PWDATA are held stable from FWD_SETUP through the end of FWD_ACCESS.

Test Plan:
- Write 0xA5A5_0001 to 0x4005_0104 (slot 1), slave ready at once -> S_PSEL=0010 for 2 cycles, S_PADDR=0x04, S_PWDATA=0xA5A50001; MSSPREADY=1 in master access cycle 3; MSSPSLVERR=0.
- Read 0x4005_0210 (slot 2), slave has 3 wait states and returns 0x1234_5678 -> MSSPREADY in access cycle 6; MSSPRDATA=0x12345678.
- Read 0x4005_0500 with NSLOTS=4 -> no S_PSEL; MSSPREADY=1, MSSPSLVERR=1, MSSPRDATA=0 in access cycle 1; ERR_COUNT=1; LAST_ERR_ADDR=0x40050500.
- TIMEOUT=8, slot 0 holds S_PREADY=0 -> S_PSEL drops after 8 access cycles; MSSPSLVERR=1; ERR_COUNT increments. A following access to slot 3 completes normally.
- Slot 3 returns S_PSLVERR=1 -> MSSPSLVERR=1 and ERR_COUNT increments. After 300 forced errors, ERR_COUNT=255.
- SYSRESET asserted during FWD_ACCESS -> next cycle S_PSEL=0, S_PENABLE=0, MSSPREADY=0, ERR_COUNT=0. The next master SETUP is accepted normally.
